// File: rtl/fp_mult_pkg.sv
// Shared definitions for the FP multiplier output path: status byte layout and result width.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fp_mult_pkg;

    localparam int ST_ZERO     = 0;
    localparam int ST_INF      = 1;
    localparam int ST_INVALID  = 2;
    localparam int ST_TINY     = 3;
    localparam int ST_HUGE     = 4;
    localparam int ST_INEXACT  = 5;
    localparam int ST_HUGEINT  = 6;
    localparam int ST_COMPSPEC = 7;

    localparam int STATUS_W = 8;
    localparam int FLAGS_W  = 4;

    // Sign bit + exponent + stored significand.
    function automatic int result_width(input int sig_width, input int exp_width);
        return sig_width + exp_width + 1;
    endfunction

endpackage

// File: rtl/fp_mult_result_collect_if.sv
// Producer/consumer handshake bundle around the multiplier result collector.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the multiplier side (in_*) and the consumer side (out_*).
interface fp_mult_result_collect_if
    import fp_mult_pkg::*;
#(
    parameter int sig_width = 23,
    parameter int exp_width = 8
);
    localparam int ZW = result_width(sig_width, exp_width);

    logic                in_valid;
    logic                in_ready;
    logic [ZW-1:0]       in_z;
    logic [STATUS_W-1:0] in_status;

    logic                out_valid;
    logic                out_ready;
    logic [ZW-1:0]       out_z;
    logic [STATUS_W-1:0] out_status;

    // slave: the collect stage; master: multiplier + consumer environment.
    modport slave (
        input  in_valid, in_z, in_status, out_ready,
        output in_ready, out_valid, out_z, out_status
    );

    modport master (
        output in_valid, in_z, in_status, out_ready,
        input  in_ready, out_valid, out_z, out_status
    );

endinterface

// File: rtl/fp_result_queue2.sv
// Two-entry FIFO holding multiplier result/status pairs.
// Latency: 1 cycle from accept to out_valid, no bypass.
// Backpressure: in_ready/out_valid decoded from the registered count only.
module fp_result_queue2
    import fp_mult_pkg::*;
#(
    parameter int ZW = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ZW-1:0]       in_z,
    input  logic [STATUS_W-1:0] in_status,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ZW-1:0]       out_z,
    output logic [STATUS_W-1:0] out_status
);

    logic [1:0][ZW-1:0]       z_mem;
    logic [1:0][STATUS_W-1:0] st_mem;
    logic                     head;
    logic                     tail;
    logic [1:0]               count;
    logic                     accept;
    logic                     pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Storage loads only on accept so gated/stale multiplier outputs never toggle flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_mem  <= '0;
            st_mem <= '0;
        end else if (accept) begin
            z_mem[tail]  <= in_z;
            st_mem[tail] <= in_status;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= 1'b0;
            tail  <= 1'b0;
            count <= 2'd0;
        end else begin
            if (accept) begin
                tail <= ~tail;
            end
            if (pop) begin
                head <= ~head;
            end
            case ({accept, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign out_z      = z_mem[head];
    assign out_status = st_mem[head];

endmodule

// File: rtl/fp_mult_result_collect.sv
// Collects DW_fp_mult_DG results into a 2-deep queue and accumulates sticky flags and a result count.
// Latency: 1 cycle from accept to out_valid; flags/count update on the accept edge.
// Backpressure: in_ready drops when both entries are occupied; it never depends on out_ready.
module fp_mult_result_collect
    import fp_mult_pkg::*;
#(
    parameter int sig_width = 23,
    parameter int exp_width = 8,
    parameter int cnt_width = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fp_mult_result_collect_if.slave bus,
    input  logic                  sticky_clr,
    output logic [FLAGS_W-1:0]    sticky_flags,
    output logic [cnt_width-1:0]  res_cnt
);

    localparam int ZW = result_width(sig_width, exp_width);

    logic                 q_in_ready;
    logic                 accept;
    logic [FLAGS_W-1:0]   new_flags;

    fp_result_queue2 #(
        .ZW (ZW)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (bus.in_valid),
        .in_ready   (q_in_ready),
        .in_z       (bus.in_z),
        .in_status  (bus.in_status),
        .out_valid  (bus.out_valid),
        .out_ready  (bus.out_ready),
        .out_z      (bus.out_z),
        .out_status (bus.out_status)
    );

    assign bus.in_ready = q_in_ready;
    assign accept       = bus.in_valid & q_in_ready;

    assign new_flags = {bus.in_status[ST_INEXACT], bus.in_status[ST_HUGE],
                        bus.in_status[ST_TINY],    bus.in_status[ST_INVALID]};

    // Clear takes effect before the same-cycle accept is folded in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= '0;
        end else if (sticky_clr) begin
            sticky_flags <= accept ? new_flags : '0;
        end else if (accept) begin
            sticky_flags <= sticky_flags | new_flags;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt <= '0;
        end else if (sticky_clr) begin
            res_cnt <= cnt_width'(accept);
        end else if (accept && (res_cnt != {cnt_width{1'b1}})) begin
            res_cnt <= res_cnt + cnt_width'(1);
        end
    end

endmodule
